// File: rtl/iob_fifo2axis_pkg.sv
// ============================================================================
// iob_fifo2axis_pkg : buffer state encoding and occupancy limit for the adapter
// Revision: 1.0
// ============================================================================
`default_nettype none

package iob_fifo2axis_pkg;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

   // Words held in the buffer plus the read in flight never exceed this.
   localparam int OCC_MAX = 2;

endpackage

`default_nettype wire

// File: rtl/iob_fifo2axis_buf.sv
// ============================================================================
// iob_fifo2axis_buf : two-entry ordered buffer (head + skid) for the stream side
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_fifo2axis_buf
   import iob_fifo2axis_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              head_valid,
   output logic [1:0]        count
);

   buf_state_t        r_state;
   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_skid;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= BUF_EMPTY;
         r_head  <= '0;
         r_skid  <= '0;
      end else if (rst) begin
         r_state <= BUF_EMPTY;
         r_head  <= '0;
         r_skid  <= '0;
      end else begin
         case (r_state)
            BUF_EMPTY: begin
               if (push) begin
                  r_head  <= push_data;
                  r_state <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (push && pop) begin
                  r_head <= push_data;
               end else if (push) begin
                  r_skid  <= push_data;
                  r_state <= BUF_TWO;
               end else if (pop) begin
                  r_state <= BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               // Skid promotes to head; a push here keeps order behind it.
               if (pop) begin
                  r_head <= r_skid;
                  if (push) begin
                     r_skid <= push_data;
                  end else begin
                     r_state <= BUF_ONE;
                  end
               end
            end
            default: r_state <= BUF_EMPTY;
         endcase
      end
   end

   assign head_data  = r_head;
   assign head_valid = (r_state != BUF_EMPTY);
   assign count      = r_state;

endmodule

`default_nettype wire

// File: rtl/iob_fifo2axis.sv
// ============================================================================
// iob_fifo2axis : drains a sync-FIFO read port into an AXI4-Stream master,
//                 framing tlast from a programmed length
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_fifo2axis
   import iob_fifo2axis_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              rst,
   input  logic              en,
   input  logic [LEN_W-1:0]  len,
   output logic              fifo_r_en,
   input  logic [DATA_W-1:0] fifo_r_data,
   input  logic              fifo_empty,
   output logic              axis_tvalid,
   input  logic              axis_tready,
   output logic [DATA_W-1:0] axis_tdata,
   output logic              axis_tlast
);

   logic              r_pend;
   logic [LEN_W-1:0]  r_cnt;
   logic              w_pop;
   logic              w_head_valid;
   logic [1:0]        w_count;
   logic [2:0]        w_occ;
   logic [2:0]        w_occ_next;
   logic [DATA_W-1:0] w_head_data;

   assign w_pop      = axis_tvalid & axis_tready;
   assign w_occ      = {1'b0, w_count} + {2'b00, r_pend};
   assign w_occ_next = w_occ - {2'b00, w_pop};

   // Ready feeds straight into the read enable so a popping cycle can refill.
   assign fifo_r_en = ~arst & ~rst & en & ~fifo_empty & (w_occ_next < 3'(OCC_MAX));

   iob_fifo2axis_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk        (clk),
      .arst       (arst),
      .rst        (rst),
      .push       (r_pend),
      .push_data  (fifo_r_data),
      .pop        (w_pop),
      .head_data  (w_head_data),
      .head_valid (w_head_valid),
      .count      (w_count)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_pend <= 1'b0;
         r_cnt  <= '0;
      end else if (rst) begin
         r_pend <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_pend <= fifo_r_en;
         if (w_pop) begin
            r_cnt <= axis_tlast ? '0 : r_cnt + LEN_W'(1);
         end
      end
   end

   assign axis_tvalid = w_head_valid;
   assign axis_tdata  = w_head_data;
   assign axis_tlast  = w_head_valid & (len != '0) & (r_cnt == len - LEN_W'(1));

endmodule

`default_nettype wire

// File: tb/tb_iob_fifo2axis.sv
// ============================================================================
// tb_iob_fifo2axis : randomized bench with a FIFO model and a scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iob_fifo2axis;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              arst;
   logic              rst;
   logic              en;
   logic [LEN_W-1:0]  len;
   logic              fifo_r_en;
   logic [DATA_W-1:0] fifo_r_data;
   logic              fifo_empty;
   logic              axis_tvalid;
   logic              axis_tready;
   logic [DATA_W-1:0] axis_tdata;
   logic              axis_tlast;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] fifo_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int  beat    = 0;
   int  rd_cnt  = 0;
   int  pop_cnt = 0;
   bit  prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic prev_last = 1'b0;

   always #5 clk = ~clk;

   iob_fifo2axis #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .rst         (rst),
      .en          (en),
      .len         (len),
      .fifo_r_en   (fifo_r_en),
      .fifo_r_data (fifo_r_data),
      .fifo_empty  (fifo_empty),
      .axis_tvalid (axis_tvalid),
      .axis_tready (axis_tready),
      .axis_tdata  (axis_tdata),
      .axis_tlast  (axis_tlast)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sync FIFO model: data appears the cycle after the read enable.
   always @(posedge clk) begin
      if (fifo_r_en) begin
         if (fifo_q.size() > 0) begin
            fifo_r_data <= fifo_q[0];
            exp_q.push_back(fifo_q[0]);
            fifo_q.delete(0);
         end else begin
            fifo_r_data <= '0;
         end
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Scoreboard: expected order is FIFO order, tlast from the beat index.
   always @(negedge clk) begin
      if (arst || rst) begin
         exp_q.delete();
         beat       = 0;
         prev_stall = 1'b0;
      end else begin
         if (fifo_r_en) begin
            rd_cnt++;
            check("read_when_empty", {63'd0, fifo_empty}, 64'd0);
         end
         check("occupancy", {63'd0, (exp_q.size() <= 2)}, 64'd1);
         if (prev_stall) begin
            check("hold_valid", {63'd0, axis_tvalid}, 64'd1);
            check("hold_data", {32'd0, axis_tdata}, {32'd0, prev_data});
            check("hold_last", {63'd0, axis_tlast}, {63'd0, prev_last});
         end
         if (!axis_tvalid) check("last_idle", {63'd0, axis_tlast}, 64'd0);
         if (axis_tvalid && axis_tready) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", 64'd1, 64'd0);
            end else begin
               check("data", {32'd0, axis_tdata}, {32'd0, exp_q[0]});
               check("tlast", {63'd0, axis_tlast},
                     {63'd0, (len != 0) && ((beat % int'(len)) == int'(len) - 1)});
               exp_q.delete(0);
            end
            beat++;
            pop_cnt++;
         end
         prev_stall = axis_tvalid && !axis_tready;
         prev_data  = axis_tdata;
         prev_last  = axis_tlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      fifo_q.push_back(d);
      fifo_empty = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0 || axis_tvalid) && k < budget) begin
         tick();
         k++;
      end
      if (k >= budget) check("drain_timeout", 64'd1, 64'd0);
   endtask

   task automatic reset_len(input int l);
      tick();
      en  = 1'b0;
      rst = 1'b1;
      len = LEN_W'(l);
      tick();
      rst = 1'b0;
      en  = 1'b1;
   endtask

   initial begin
      int rd0;
      int pc0;
      arst = 1'b1; rst = 1'b0; en = 1'b1; len = 16'd4;
      axis_tready = 1'b1; fifo_empty = 1'b1; fifo_r_data = '0;
      for (int i = 0; i < 8; i++) push(32'h10 + i);
      repeat (3) tick();
      @(negedge clk);
      check("reset_ren", {63'd0, fifo_r_en}, 64'd0);
      check("reset_valid", {63'd0, axis_tvalid}, 64'd0);
      check("reset_data", {32'd0, axis_tdata}, 64'd0);
      check("reset_last", {63'd0, axis_tlast}, 64'd0);

      // Streaming with len=4.
      tick();
      arst = 1'b0;
      @(negedge clk);
      check("first_ren", {63'd0, fifo_r_en}, 64'd1);
      @(negedge clk);
      check("latency_t1", {63'd0, axis_tvalid}, 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("stream_gap", {63'd0, axis_tvalid}, 64'd1);
      end
      wait_idle(50);

      // Back-pressure.
      tick();
      axis_tready = 1'b0;
      for (int i = 0; i < 5; i++) push(32'h10 + i);
      rd0 = rd_cnt;
      repeat (10) tick();
      @(negedge clk);
      check("bp_reads", 64'(rd_cnt - rd0), 64'd2);
      check("bp_data", {32'd0, axis_tdata}, 64'h10);
      tick();
      axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_gap", {63'd0, axis_tvalid}, 64'd1);
      end
      wait_idle(50);

      // Bursty sink with len=3.
      reset_len(3);
      axis_tready = 1'b0;
      pc0 = pop_cnt;
      for (int i = 0; i < 10; i++) push($urandom);
      for (int i = 0; i < 40; i++) begin
         axis_tready = (i % 2 == 0);
         tick();
      end
      axis_tready = 1'b1;
      wait_idle(50);
      check("bursty_count", 64'(pop_cnt - pc0), 64'd10);

      // Empty FIFO.
      @(negedge clk);
      check("empty_ren", {63'd0, fifo_r_en}, 64'd0);
      check("empty_valid", {63'd0, axis_tvalid}, 64'd0);
      tick();
      pc0 = pop_cnt;
      push($urandom);
      wait_idle(20);
      repeat (2) tick();
      @(negedge clk);
      check("single_count", 64'(pop_cnt - pc0), 64'd1);
      check("single_valid_off", {63'd0, axis_tvalid}, 64'd0);

      // Unframed, with en dropped mid-stream.
      reset_len(0);
      for (int i = 0; i < 20; i++) push($urandom);
      for (int i = 0; i < 8; i++) begin
         axis_tready = 1'($urandom_range(0, 1));
         tick();
      end
      en = 1'b0;
      axis_tready = 1'b1;
      tick();
      rd0 = rd_cnt;
      repeat (10) tick();
      @(negedge clk);
      check("en_low_reads", 64'(rd_cnt - rd0), 64'd0);
      check("en_low_drained", 64'(exp_q.size()), 64'd0);
      check("en_low_valid", {63'd0, axis_tvalid}, 64'd0);
      tick();
      en = 1'b1;
      wait_idle(100);

      // Sync reset one cycle after a read.
      reset_len(3);
      axis_tready = 1'b1;
      for (int i = 0; i < 6; i++) push($urandom);
      @(negedge clk);
      check("pre_rst_ren", {63'd0, fifo_r_en}, 64'd1);
      tick();
      rst = 1'b1;
      pc0 = pop_cnt;
      @(negedge clk);
      check("rst_ren", {63'd0, fifo_r_en}, 64'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", {63'd0, axis_tvalid}, 64'd0);
      wait_idle(50);
      check("rst_dropped", 64'(pop_cnt - pc0), 64'd5);

      // Randomized traffic with varying frame lengths.
      for (int r = 0; r < 4; r++) begin
         reset_len($urandom_range(1, 5));
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0) push($urandom);
            axis_tready = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 7) != 0);
            tick();
         end
         en = 1'b1;
         axis_tready = 1'b1;
         wait_idle(200);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
